// File: rtl/mem_access_ctrl.sv
// Multicycle fetch/decode/execute sequencer for the shared memory-address path.
// Optional build macro MEM_TIMEOUT_EN adds a per-access wait timeout and sticky mem_err.
module mem_access_ctrl #(
    parameter logic [3:0] OP_LD   = 4'b0010,
    parameter logic [3:0] OP_ST   = 4'b0011,
    parameter logic [3:0] OP_HALT = 4'b1111
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 15
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [3:0]  ir_opcode,
    output logic        select,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        reg_we,
    output logic        busy,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] instr_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_DATA_RD = 3'd4,
        S_DATA_WR = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] cnt_q;
    logic        retire;
    logic        ir_load_c, pc_inc_c, reg_we_c;
    logic        mem_phase;
    logic        timeout;
    logic        err_q;

    assign mem_phase = (state_q == S_FETCH) || (state_q == S_DATA_RD) ||
                       (state_q == S_DATA_WR);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_q;

    assign timeout = mem_phase && !mem_ready &&
                     (wait_q == 8'(TIMEOUT_CYCLES - 1));

    // Wait counter restarts on every state change, so each access gets a fresh budget
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            if (timeout)
                err_q <= 1'b1;
            if (state_d != state_q)
                wait_q <= 8'd0;
            else if (mem_phase && !mem_ready)
                wait_q <= wait_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        retire    = 1'b0;
        ir_load_c = 1'b0;
        pc_inc_c  = 1'b0;
        reg_we_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!run)
                    halted_d = 1'b0;
                else if (!halted_q && !err_q)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_load_c = 1'b1;
                    pc_inc_c  = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                if (ir_opcode == OP_LD)
                    state_d = S_DATA_RD;
                else if (ir_opcode == OP_ST)
                    state_d = S_DATA_WR;
                else if (ir_opcode == OP_HALT) begin
                    halted_d = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_IDLE;
                end else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                reg_we_c = 1'b1;
                retire   = 1'b1;
                state_d  = run ? S_FETCH : S_IDLE;
            end
            S_DATA_RD: begin
                if (mem_ready) begin
                    reg_we_c = 1'b1;
                    retire   = 1'b1;
                    state_d  = run ? S_FETCH : S_IDLE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA_WR: begin
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            if (retire)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    // Every output is forced low while reset is held, including mid-access
    assign select      = !reset && ((state_q == S_DATA_RD) || (state_q == S_DATA_WR));
    assign mem_req     = !reset && mem_phase;
    assign mem_we      = !reset && (state_q == S_DATA_WR);
    assign busy        = !reset && (state_q != S_IDLE);
    assign ir_load     = !reset && ir_load_c;
    assign pc_inc      = !reset && pc_inc_c;
    assign reg_we      = !reset && reg_we_c;
    assign halted      = !reset && halted_q;
    assign mem_err     = !reset && err_q;
    assign instr_count = reset ? 16'd0 : cnt_q;
    assign state       = reset ? 3'd0 : state_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Multicycle sequencer for the shared memory-address path of the 16-bit processor.
- Owns the select input of the 2:1 address mux: select=0 routes zero-extended PC, select=1 routes zero-extended register A.
- Issues memory requests and sequences fetch, decode and execute, including load/store data accesses through the same address path.
- Produces load/enable strobes for IR, PC and the register file.
- Maintains a retired-instruction counter.

Parameters:
OP_LD, 4'b0010, opcode (ir_opcode) of the load instruction; performs a data read at regA.
OP_ST, 4'b0011, opcode of the store instruction; performs a data write at regA.
OP_HALT, 4'b1111, opcode that stops sequencing.
TIMEOUT_CYCLES, 15, maximum wait cycles per memory access; used only with MEM_TIMEOUT_EN.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = sequence instructions, 0 = stop after the current instruction
mem_ready  in  1  memory completion, valid only while mem_req=1
ir_opcode  in  4  IR[15:12]; valid from the cycle after ir_load
select  out  1  address mux select: 0 = pc, 1 = regA
mem_req  out  1  memory access request
mem_we  out  1  1 = write access (meaningful only with mem_req)
ir_load  out  1  one-cycle strobe: capture memory data into IR
pc_inc  out  1  one-cycle strobe: PC <= PC+1
reg_we  out  1  one-cycle strobe: register-file write
busy  out  1  1 in any state other than IDLE
halted  out  1  sticky; set by HALT
mem_err  out  1  sticky; memory timeout (always 0 without MEM_TIMEOUT_EN)
instr_count  out  16  retired-instruction count
state  out  3  current state encoding, for debug

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE, halted=0, mem_err=0, instr_count=0.
  - While reset=1, every output is 0.
- Output classes:
  - select, mem_req, mem_we, busy, state are Moore outputs (decoded from state only).
  - ir_load, pc_inc, reg_we are Mealy pulses, asserted in the cycle the transition condition holds. Each lasts exactly 1 cycle.
- States (encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, DATA_RD=4, DATA_WR=5.
- IDLE:
  - Outputs: select=0, mem_req=0.
  - run=1 and halted=0 -> FETCH.
  - run=0 -> clear halted; stay in IDLE.
- FETCH:
  - Outputs: select=0, mem_req=1, mem_we=0.
  - mem_ready=1 -> assert ir_load and pc_inc; go to DECODE.
  - Otherwise hold in FETCH (unbounded wait without the macro).
- DECODE:
  - Registered-wait state; no memory access; single cycle.
  - ir_opcode=OP_LD -> DATA_RD.
  - ir_opcode=OP_ST -> DATA_WR.
  - ir_opcode=OP_HALT -> set halted, increment instr_count, go to IDLE.
  - Any other opcode -> EXEC.
- EXEC:
  - Single cycle; reg_we=1; retire; go to NEXT.
- DATA_RD:
  - Outputs: select=1, mem_req=1, mem_we=0.
  - mem_ready=1 -> reg_we=1; retire; go to NEXT.
- DATA_WR:
  - Outputs: select=1, mem_req=1, mem_we=1.
  - mem_ready=1 -> retire; go to NEXT. No reg_we.
- Retire = instr_count+1, wrapping 16'hFFFF -> 16'h0000.
- NEXT = FETCH if run=1, else IDLE. run is sampled in the retiring cycle only.
- run falling mid-instruction:
  - The current instruction completes, including any outstanding memory access.
  - mem_req is never dropped before mem_ready.
- mem_ready outside FETCH, DATA_RD or DATA_WR is ignored.
- reset asserted mid-access:
  - mem_req drops in the reset cycle.
  - No strobes are issued; instr_count is not incremented.
- Latency (mem_ready returned in the same cycle as the request):
  - ALU instruction: 3 cycles.
  - LD/ST: 3 cycles.
  - Back-to-back instructions: no bubble between retire and the next FETCH.
- select is stable for every cycle in which mem_req=1.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A 4-bit-or-wider wait counter clears on entry to FETCH, DATA_RD or DATA_WR and increments each cycle mem_ready=0.
  - If the counter reaches TIMEOUT_CYCLES with mem_ready still 0: abort to IDLE, set mem_err, issue no strobes, do not retire.
  - mem_err clears only on reset.
  - While mem_err=1, IDLE does not leave for FETCH.
- Undefined:
  - No counter; waits are unbounded; mem_err is tied to 0.

Test Plan:
- ALU sequence:
  - Reset, run=1, mem_ready tied 1, ir_opcode=4'b0001.
  - Required: states 1,2,3 repeating; ir_load and pc_inc pulse every 3 cycles with select=0; reg_we pulses in EXEC; instr_count=3 after 9 cycles.
- Load with memory wait:
  - ir_opcode=OP_LD, mem_ready low for 4 cycles in DATA_RD.
  - Required: select=1 and mem_req=1 held for 5 cycles; a single reg_we pulse on the mem_ready cycle; then FETCH with select=0.
- Store:
  - ir_opcode=OP_ST.
  - Required: mem_we=1 only in DATA_WR; no reg_we; instr_count increments once.
- Halt then restart:
  - ir_opcode=OP_HALT.
  - Required: halted=1 and busy=0 in IDLE, holding with run=1.
  - Then run=0 for 1 cycle, then run=1: halted clears and FETCH resumes.
- run and reset mid-operation:
  - run=0 during a DATA_RD wait: the access completes, then IDLE.
  - reset during FETCH: all outputs 0 next cycle; instr_count=0.
- Counter wrap and timeout:
  - Preload to 16'hFFFE by running 65534 instructions; two more retires give 16'h0000.
  - With MEM_TIMEOUT_EN and mem_ready=0: after 15 FETCH cycles, mem_err=1, state=IDLE, no ir_load.
